// File: rtl/cve2_trace_pkg.sv
// Shared types for the cve2 retirement trace buffer: record layout,
// capture modes, trigger FSM states and the mode decode helper.
package cve2_trace_pkg;

    localparam int unsigned TraceEntryW = 103;

    // Record layout, MSB first: {pc, insn, rd_addr, rd_wdata, trap, intr}
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic        trap;
        logic        intr;
    } trace_entry_t;

    typedef enum logic [1:0] {
        TRACE_CONT = 2'd0,
        TRACE_WRAP = 2'd1,
        TRACE_TRIG = 2'd2
    } trace_mode_e;

    typedef enum logic [1:0] {
        TRIG_ARMED = 2'd0,
        TRIG_POST  = 2'd1,
        TRIG_DONE  = 2'd2
    } trig_state_e;

    // The unused encoding 3 falls back to stop-when-full capture.
    function automatic trace_mode_e decode_mode(logic [1:0] mode);
        trace_mode_e res;
        case (mode)
            2'd1:    res = TRACE_WRAP;
            2'd2:    res = TRACE_TRIG;
            default: res = TRACE_CONT;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cve2_trace_fifo.sv
// Circular record store with separate level tracking. A push into a full
// store either replaces the oldest record (overwrite_i) or is dropped,
// unless a pop happens in the same cycle. Pops on an empty store are ignored.
module cve2_trace_fifo
    import cve2_trace_pkg::*;
#(
    parameter int unsigned Depth = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic                      overwrite_i,
    input  logic [TraceEntryW-1:0]    push_entry_i,
    output logic [TraceEntryW-1:0]    head_o,
    output logic [$clog2(Depth):0]    level_o,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]        level_q, level_d;
    logic [TraceEntryW-1:0] mem_q [Depth];
    logic                   wr_en_s;
    logic                   full_s;
    logic                   empty_s;
    logic                   pop_ok_s;

    assign empty_s  = (level_q == {LvlW{1'b0}});
    assign full_s   = (level_q == LvlW'(Depth));
    assign pop_ok_s = pop_i & ~empty_s;

    // Next pointer/level computation; clear wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        wr_en_s  = 1'b0;
        if (clear_i) begin
            wr_ptr_d = {PtrW{1'b0}};
            rd_ptr_d = {PtrW{1'b0}};
            level_d  = {LvlW{1'b0}};
        end else if (push_i) begin
            if (!full_s) begin
                wr_en_s  = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (pop_ok_s) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end else begin
                    level_d = level_q + 1'b1;
                end
            end else if (pop_ok_s || overwrite_i) begin
                // Full: the slot being written is the head slot, so the
                // read pointer moves on with the write pointer.
                wr_en_s  = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                wr_en_s = 1'b0;
            end
        end else if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            level_d  = level_q - 1'b1;
        end else begin
            level_d = level_q;
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PtrW{1'b0}};
            rd_ptr_q <= {PtrW{1'b0}};
            level_q  <= {LvlW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Record storage; contents are only visible while level is non-zero.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o  = empty_s ? {TraceEntryW{1'b0}} : mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = full_s;
    assign empty_o = empty_s;

endmodule

// File: rtl/cve2_trace_buffer.sv
// On-chip capture buffer for the cve2 RVFI retirement stream. Holds the
// latched capture configuration, capture gating, PC trigger FSM and the
// saturating overflow counter around a circular record store.
module cve2_trace_buffer
    import cve2_trace_pkg::*;
#(
    parameter int unsigned Depth    = 16,
    parameter int unsigned OvfWidth = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic [1:0]                mode_i,
    input  logic [31:0]               trig_pc_i,
    input  logic [$clog2(Depth):0]    post_count_i,
    input  logic                      rvfi_valid_i,
    input  logic [31:0]               rvfi_pc_rdata_i,
    input  logic [31:0]               rvfi_insn_i,
    input  logic                      rvfi_trap_i,
    input  logic                      rvfi_intr_i,
    input  logic [4:0]                rvfi_rd_addr_i,
    input  logic [31:0]               rvfi_rd_wdata_i,
    output logic                      rd_valid_o,
    input  logic                      rd_ready_i,
    output logic [TraceEntryW-1:0]    rd_entry_o,
    output logic [$clog2(Depth):0]    level_o,
    output logic [OvfWidth-1:0]       ovf_cnt_o,
    output logic [1:0]                trig_state_o
);

    localparam int unsigned LvlW = $clog2(Depth) + 1;

    trace_mode_e        mode_q, mode_d;
    trig_state_e        state_q, state_d;
    logic [31:0]        trig_pc_q, trig_pc_d;
    logic [LvlW-1:0]    post_count_q, post_count_d;
    logic [LvlW-1:0]    remaining_q, remaining_d;
    logic [OvfWidth-1:0] ovf_q, ovf_d;

    trace_entry_t       push_entry_s;
    logic               capture_s;
    logic               full_s;
    logic               empty_s;
    logic               ovf_event_s;
    logic               trig_hit_s;

    assign push_entry_s = '{
        pc:       rvfi_pc_rdata_i,
        insn:     rvfi_insn_i,
        rd_addr:  rvfi_rd_addr_i,
        rd_wdata: rvfi_rd_wdata_i,
        trap:     rvfi_trap_i,
        intr:     rvfi_intr_i
    };

    assign capture_s   = rvfi_valid_i & enable_i & (state_q != TRIG_DONE);
    // A full store loses a record (dropped or overwritten) unless a pop
    // frees the slot in the same cycle.
    assign ovf_event_s = capture_s & full_s & ~rd_ready_i;
    assign trig_hit_s  = capture_s & (mode_q == TRACE_TRIG) & (state_q == TRIG_ARMED)
                       & (rvfi_pc_rdata_i == trig_pc_q);

    cve2_trace_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .push_i       (capture_s),
        .pop_i        (rd_ready_i),
        .overwrite_i  (mode_q != TRACE_CONT),
        .push_entry_i (push_entry_s),
        .head_o       (rd_entry_o),
        .level_o      (level_o),
        .full_o       (full_s),
        .empty_o      (empty_s)
    );

    // Config latching, overflow counting and trigger FSM next state.
    always_comb begin
        mode_d       = mode_q;
        trig_pc_d    = trig_pc_q;
        post_count_d = post_count_q;
        remaining_d  = remaining_q;
        state_d      = state_q;
        ovf_d        = ovf_q;
        if (clear_i) begin
            mode_d       = decode_mode(mode_i);
            trig_pc_d    = trig_pc_i;
            post_count_d = post_count_i;
            remaining_d  = {LvlW{1'b0}};
            state_d      = TRIG_ARMED;
            ovf_d        = {OvfWidth{1'b0}};
        end else begin
            if (ovf_event_s && (ovf_q != {OvfWidth{1'b1}})) begin
                ovf_d = ovf_q + 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
            case (state_q)
                TRIG_ARMED: begin
                    if (trig_hit_s) begin
                        if (post_count_q == {LvlW{1'b0}}) begin
                            state_d = TRIG_DONE;
                        end else begin
                            remaining_d = post_count_q;
                            state_d     = TRIG_POST;
                        end
                    end else begin
                        state_d = TRIG_ARMED;
                    end
                end
                TRIG_POST: begin
                    if (capture_s) begin
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == {{(LvlW-1){1'b0}}, 1'b1}) begin
                            state_d = TRIG_DONE;
                        end else begin
                            state_d = TRIG_POST;
                        end
                    end else begin
                        state_d = TRIG_POST;
                    end
                end
                TRIG_DONE: begin
                    state_d = TRIG_DONE;
                end
                default: begin
                    state_d = TRIG_ARMED;
                end
            endcase
        end
    end

    // Config, FSM and overflow counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q       <= TRACE_CONT;
            trig_pc_q    <= 32'h0000_0000;
            post_count_q <= {LvlW{1'b0}};
            remaining_q  <= {LvlW{1'b0}};
            state_q      <= TRIG_ARMED;
            ovf_q        <= {OvfWidth{1'b0}};
        end else begin
            mode_q       <= mode_d;
            trig_pc_q    <= trig_pc_d;
            post_count_q <= post_count_d;
            remaining_q  <= remaining_d;
            state_q      <= state_d;
            ovf_q        <= ovf_d;
        end
    end

    assign rd_valid_o   = ~empty_s;
    assign ovf_cnt_o    = ovf_q;
    assign trig_state_o = state_q;

endmodule

// File: tb/tb_cve2_trace_buffer.sv
// Self-checking bench for cve2_trace_buffer: directed scenarios with
// hand-computed expectations plus randomized traffic against a queue model.
module tb_cve2_trace_buffer;

    localparam int DEPTH = 16;
    localparam int OVFW  = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable, clear, valid, trap, intr, rd_ready;
    logic [1:0]   mode;
    logic [31:0]  trig_pc, pc, insn, rd_wdata;
    logic [4:0]   post_count, rd_addr;
    logic         rd_valid;
    logic [102:0] rd_entry;
    logic [4:0]   level;
    logic [OVFW-1:0] ovf;
    logic [1:0]   trig_state;

    int tests = 0;
    int fails = 0;

    // behavioural model state
    logic [102:0] mq[$];
    int           m_ovf = 0;
    int           m_mode = 0;
    logic [31:0]  m_trig_pc = 32'h0;
    int           m_post = 0;
    int           m_rem = 0;
    int           m_state = 0;

    always #5 clk = ~clk;

    cve2_trace_buffer #(.Depth(DEPTH), .OvfWidth(OVFW)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (enable),
        .clear_i         (clear),
        .mode_i          (mode),
        .trig_pc_i       (trig_pc),
        .post_count_i    (post_count),
        .rvfi_valid_i    (valid),
        .rvfi_pc_rdata_i (pc),
        .rvfi_insn_i     (insn),
        .rvfi_trap_i     (trap),
        .rvfi_intr_i     (intr),
        .rvfi_rd_addr_i  (rd_addr),
        .rvfi_rd_wdata_i (rd_wdata),
        .rd_valid_o      (rd_valid),
        .rd_ready_i      (rd_ready),
        .rd_entry_o      (rd_entry),
        .level_o         (level),
        .ovf_cnt_o       (ovf),
        .trig_state_o    (trig_state)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of records updated once per clock edge.
    initial begin
        logic cap, pop;
        logic [102:0] rec;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_ovf = 0; m_mode = 0; m_trig_pc = 32'h0;
                m_post = 0; m_rem = 0; m_state = 0;
            end else if (clear) begin
                mq.delete();
                m_ovf = 0;
                m_mode = (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 0;
                m_trig_pc = trig_pc;
                m_post = int'(post_count);
                m_rem = 0;
                m_state = 0;
            end else begin
                rec = {pc, insn, rd_addr, rd_wdata, trap, intr};
                cap = valid && enable && (m_state != 2);
                pop = rd_ready && (mq.size() > 0);
                if (pop) void'(mq.pop_front());
                if (cap) begin
                    if (mq.size() == DEPTH) begin
                        if (m_ovf < (1 << OVFW) - 1) m_ovf++;
                        if (m_mode != 0) begin
                            void'(mq.pop_front());
                            mq.push_back(rec);
                        end
                    end else begin
                        mq.push_back(rec);
                    end
                    if (m_mode == 2) begin
                        if (m_state == 0 && pc == m_trig_pc) begin
                            if (m_post == 0) m_state = 2;
                            else begin m_state = 1; m_rem = m_post; end
                        end else if (m_state == 1) begin
                            m_rem--;
                            if (m_rem == 0) m_state = 2;
                        end
                    end
                end
            end
        end
    end

    // Compare DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("rd_valid", rd_valid, mq.size() > 0);
            check("rd_entry", rd_entry, (mq.size() > 0) ? mq[0] : 103'd0);
            check("level", level, mq.size());
            check("ovf_cnt", ovf, m_ovf);
            check("trig_state", trig_state, m_state);
        end
    end

    // Entered and left at a negedge.
    task automatic do_clear(input logic [1:0] m, input logic [31:0] tpc, input logic [4:0] post);
        clear = 1'b1; mode = m; trig_pc = tpc; post_count = post;
        valid = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic set_retire(input logic [31:0] p);
        valid = 1'b1; pc = p; insn = $urandom; rd_wdata = $urandom;
        rd_addr = 5'($urandom_range(0, 31));
        trap = 1'($urandom_range(0, 1)); intr = 1'($urandom_range(0, 1));
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            set_retire(base + 32'(4 * k));
            @(negedge clk);
        end
        valid = 1'b0;
    endtask

    task automatic drain(output logic [31:0] first, output logic [31:0] last, output int cnt);
        cnt = 0; first = 32'h0; last = 32'h0;
        valid = 1'b0; rd_ready = 1'b1;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (rd_valid) begin
                if (cnt == 0) first = rd_entry[102:71];
                last = rd_entry[102:71];
                cnt++;
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] f, l;
        int c;
        enable = 1'b1; clear = 1'b0; valid = 1'b0; rd_ready = 1'b0;
        mode = 2'd0; trig_pc = 32'h0; post_count = 5'd0;
        pc = 32'h0; insn = 32'h0; rd_wdata = 32'h0; rd_addr = 5'd0;
        trap = 1'b0; intr = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_level", level, 5'd0);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_entry", rd_entry, 103'd0);
        check("rst_ovf", ovf, 16'd0);
        check("rst_state", trig_state, 2'd0);
        #2 rst = 1'b0;
        @(negedge clk);

        // stop-when-full
        do_clear(2'd0, 32'h0, 5'd0);
        push_seq(32'h100, 20);
        check("cont_level", level, 5'd16);
        check("cont_ovf", ovf, 16'd4);
        drain(f, l, c);
        check("cont_first", f, 32'h100);
        check("cont_last", l, 32'h13C);
        check("cont_cnt", c, 16);

        // overwrite-oldest
        do_clear(2'd1, 32'h0, 5'd0);
        push_seq(32'h100, 20);
        check("wrap_level", level, 5'd16);
        check("wrap_ovf", ovf, 16'd4);
        drain(f, l, c);
        check("wrap_first", f, 32'h110);
        check("wrap_last", l, 32'h14C);

        // PC trigger with three post-trigger entries
        do_clear(2'd2, 32'h200, 5'd3);
        push_seq(32'h1F0, 13);
        check("trig3_state", trig_state, 2'd2);
        check("trig3_level", level, 5'd8);
        check("trig3_ovf", ovf, 16'd0);
        drain(f, l, c);
        check("trig3_first", f, 32'h1F0);
        check("trig3_last", l, 32'h20C);
        check("trig3_cnt", c, 8);

        // PC trigger with no post-trigger entries
        do_clear(2'd2, 32'h200, 5'd0);
        for (int k = 0; k < 5; k++) begin
            set_retire(32'h1F8 + 32'(4 * k));
            @(negedge clk);
            if (k == 2) check("trig0_done", trig_state, 2'd2);
        end
        valid = 1'b0;
        drain(f, l, c);
        check("trig0_last", l, 32'h200);
        check("trig0_cnt", c, 3);

        // full buffer with simultaneous push and pop, WRAP then CONT
        for (int mm = 1; mm >= 0; mm--) begin
            do_clear(2'(mm), 32'h0, 5'd0);
            push_seq(32'h300, 16);
            rd_ready = 1'b1;
            push_seq(32'h340, 32);
            rd_ready = 1'b0;
            check("pp_level", level, 5'd16);
            check("pp_ovf", ovf, 16'd0);
            check("pp_head", rd_entry[102:71], 32'h380);
            repeat (3) @(negedge clk);
            check("pp_hold", rd_entry[102:71], 32'h380);
        end

        // clear together with a retirement; new TRIG config takes effect
        clear = 1'b1; mode = 2'd2; trig_pc = 32'h400; post_count = 5'd1;
        set_retire(32'h400);
        @(negedge clk);
        clear = 1'b0; valid = 1'b0;
        check("clr_level", level, 5'd0);
        check("clr_valid", rd_valid, 1'b0);
        check("clr_ovf", ovf, 16'd0);
        push_seq(32'h400, 1);
        check("clr_post", trig_state, 2'd1);
        push_seq(32'h404, 1);
        check("clr_done", trig_state, 2'd2);
        push_seq(32'h408, 2);
        check("clr_ignored", level, 5'd2);

        // asynchronous reset between clock edges
        do_clear(2'd1, 32'h0, 5'd0);
        push_seq(32'h500, 5);
        #2 rst = 1'b1;
        #1;
        check("arst_level", level, 5'd0);
        check("arst_valid", rd_valid, 1'b0);
        check("arst_entry", rd_entry, 103'd0);
        check("arst_ovf", ovf, 16'd0);
        check("arst_state", trig_state, 2'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        push_seq(32'h600, 18);
        check("arst_cont_ovf", ovf, 16'd2);
        drain(f, l, c);

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            clear = ($urandom_range(0, 99) < 3);
            mode = 2'($urandom_range(0, 3));
            trig_pc = 32'h200 + 32'(4 * $urandom_range(0, 7));
            post_count = 5'($urandom_range(0, 5));
            enable = ($urandom_range(0, 9) != 0);
            rd_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) < 7) set_retire(32'h200 + 32'(4 * $urandom_range(0, 7)));
            else valid = 1'b0;
            @(negedge clk);
        end
        clear = 1'b0; valid = 1'b0; rd_ready = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
